// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with programmable thresholds,
// wr_ack/overflow/underflow pulses and a read-valid strobe.
// Optional first-word-fall-through read mode: define SYNC_FIFO_FWFT_EN.
// Without the macro, reads are registered with one cycle of latency.
module sync_fifo_param #(
  parameter int unsigned DATA_W        = 4,
  parameter int unsigned ADDR_W        = 5,
  parameter int unsigned PROG_FULL_TH  = 28,
  parameter int unsigned PROG_EMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              prog_full,
  output logic              prog_empty,
  output logic              wr_ack,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   data_count
);

  localparam int unsigned     Depth   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthC  = (ADDR_W + 1)'(Depth);
  localparam logic [ADDR_W:0] FullTh  = (ADDR_W + 1)'(PROG_FULL_TH);
  localparam logic [ADDR_W:0] EmptyTh = (ADDR_W + 1)'(PROG_EMPTY_TH);
  localparam logic [ADDR_W-1:0] PtrOne = 1;
  localparam logic [ADDR_W:0]   CntOne = 1;

  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, empty_q, prog_full_q, prog_empty_q;
  logic              wr_ack_q, overflow_q, underflow_q;
  logic              wr_acc, rd_acc;

  // Acceptance is decided by the flags registered at the start of the cycle.
  assign wr_acc = wr_en && !full_q;
  assign rd_acc = rd_en && !empty_q;

  // Next occupancy; flags are derived from this so they track data_count exactly.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, status flags and request pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      prog_full_q  <= 1'b0;
      prog_empty_q <= 1'b1;
      wr_ack_q     <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_acc) rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q      <= count_d;
      full_q       <= (count_d == DepthC);
      empty_q      <= (count_d == '0);
      prog_full_q  <= (count_d >= FullTh);
      prog_empty_q <= (count_d <= EmptyTh);
      wr_ack_q     <= wr_acc;
      overflow_q   <= wr_en && !wr_acc;
      underflow_q  <= rd_en && !rd_acc;
    end
  end

  // Storage array; contents are not reset, the pointers define what is live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; mem is registered so din never reaches dout directly.
  assign dout  = mem[rd_ptr_q];
  assign valid = !empty_q;
`else
  logic [DATA_W-1:0] dout_q;
  logic              valid_q;

  // Registered read port: word appears one cycle after an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  assign dout  = dout_q;
  assign valid = valid_q;
`endif

  assign full       = full_q;
  assign empty      = empty_q;
  assign prog_full  = prog_full_q;
  assign prog_empty = prog_empty_q;
  assign wr_ack     = wr_ack_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign data_count = count_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (4 bits x 32 words).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       wr_en, rd_en;
  logic [3:0] dout;
  logic       valid, full, empty, prog_full, prog_empty;
  logic       wr_ack, overflow, underflow;
  logic [5:0] data_count;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(
    .DATA_W       (4),
    .ADDR_W       (5),
    .PROG_FULL_TH (28),
    .PROG_EMPTY_TH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .valid     (valid),
    .full      (full),
    .empty     (empty),
    .prog_full (prog_full),
    .prog_empty(prog_empty),
    .wr_ack    (wr_ack),
    .overflow  (overflow),
    .underflow (underflow),
    .data_count(data_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; wr_en = 1'b0; rd_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({empty, prog_empty, full, prog_full, valid} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_flags cyc%0d got e/pe/f/pf/v=%b want 11000", i,
                 {empty, prog_empty, full, prog_full, valid});
      end
      checks++;
      if ({wr_ack, overflow, underflow} !== 3'b000 || data_count !== 6'd0) begin
        errors++;
        $display("FAIL reset_pulses cyc%0d got ack/ov/un=%b cnt=%0d want 000 cnt=0", i,
                 {wr_ack, overflow, underflow}, data_count);
      end
    end
    checks++;
    if (dout !== 4'h0) begin
      errors++;
      $display("FAIL reset_dout got %h want 0", dout);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      din = 4'(i); wr_en = 1'b1;
      tick();
      checks++;
      if (wr_ack !== 1'b1 || data_count !== 6'(i + 1)) begin
        errors++;
        $display("FAIL fill_ack w%0d got ack=%b cnt=%0d want ack=1 cnt=%0d", i, wr_ack,
                 data_count, i + 1);
      end
      checks++;
      if (prog_full !== (i + 1 >= 28) || full !== (i + 1 == 32) || empty !== 1'b0 ||
          prog_empty !== (i + 1 <= 4)) begin
        errors++;
        $display("FAIL fill_flags w%0d got pf=%b f=%b e=%b pe=%b cnt=%0d", i, prog_full, full,
                 empty, prog_empty, i + 1);
      end
    end
    din = 4'h5;
    tick();
    checks++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || data_count !== 6'd32) begin
      errors++;
      $display("FAIL overflow got ov=%b ack=%b cnt=%0d want 1 0 32", overflow, wr_ack,
               data_count);
    end
    wr_en = 1'b0;
    tick();
    checks++;
    if (overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL overflow_pulse got ov=%b full=%b want 0 1", overflow, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 32; i++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (valid !== 1'b1 || dout !== 4'(i) || data_count !== 6'(31 - i)) begin
        errors++;
        $display("FAIL drain_data r%0d got v=%b dout=%h cnt=%0d want 1 %h %0d", i, valid, dout,
                 data_count, 4'(i), 31 - i);
      end
      checks++;
      if (empty !== (i == 31) || prog_empty !== (31 - i <= 4) || full !== 1'b0) begin
        errors++;
        $display("FAIL drain_flags r%0d got e=%b pe=%b f=%b", i, empty, prog_empty, full);
      end
    end
    tick();
    checks++;
    if (underflow !== 1'b1 || valid !== 1'b0 || data_count !== 6'd0) begin
      errors++;
      $display("FAIL underflow got un=%b v=%b cnt=%0d want 1 0 0", underflow, valid, data_count);
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (underflow !== 1'b0 || dout !== 4'hF) begin
      errors++;
      $display("FAIL underflow_pulse got un=%b dout=%h want 0 f", underflow, dout);
    end
  endtask

  // Word n of the stream carries n[3:0]; reads must come out in the same order.
  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      din = 4'(i); wr_en = 1'b1;
      tick();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      din = 4'(16 + k);
      tick();
      checks++;
      if (valid !== 1'b1 || dout !== 4'(k) || data_count !== 6'd16 ||
          overflow !== 1'b0 || underflow !== 1'b0) begin
        errors++;
        $display("FAIL stream c%0d got v=%b dout=%h cnt=%0d ov=%b un=%b want dout=%h cnt=16", k,
                 valid, dout, data_count, overflow, underflow, 4'(k));
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    // Count is 16 with head word 40 (0x8); top up to full.
    for (int i = 0; i < 16; i++) begin
      din = 4'(i); wr_en = 1'b1;
      tick();
    end
    checks++;
    if (full !== 1'b1 || data_count !== 6'd32) begin
      errors++;
      $display("FAIL topup got full=%b cnt=%0d want 1 32", full, data_count);
    end
    din = 4'h3; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    checks++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || data_count !== 6'd31 || valid !== 1'b1 ||
        dout !== 4'h8) begin
      errors++;
      $display("FAIL full_rw got ov=%b ack=%b cnt=%0d v=%b dout=%h want 1 0 31 1 8", overflow,
               wr_ack, data_count, valid, dout);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    checks++;
    if (empty !== 1'b1 || data_count !== 6'd0) begin
      errors++;
      $display("FAIL drain31 got e=%b cnt=%0d want 1 0", empty, data_count);
    end
    din = 4'h6; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    checks++;
    if (underflow !== 1'b1 || wr_ack !== 1'b1 || data_count !== 6'd1 || valid !== 1'b0 ||
        empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rw got un=%b ack=%b cnt=%0d v=%b e=%b want 1 1 1 0 0", underflow,
               wr_ack, data_count, valid, empty);
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      din = 4'(i + 1); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({empty, prog_empty, full, prog_full, wr_ack} !== 5'b11000 || data_count !== 6'd0) begin
      errors++;
      $display("FAIL async_reset got e/pe/f/pf/ack=%b cnt=%0d want 11000 0",
               {empty, prog_empty, full, prog_full, wr_ack}, data_count);
    end
    tick();
    rst = 1'b0;
    din = 4'hA; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++;
    if (data_count !== 6'd1 || wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_wr got cnt=%0d ack=%b want 1 1", data_count, wr_ack);
    end
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (dout !== 4'hA || valid !== 1'b1) begin
      errors++;
      $display("FAIL fwft_head got dout=%h v=%b want a 1", dout, valid);
    end
`else
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout !== 4'hA || valid !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_rd got dout=%h v=%b e=%b want a 1 1", dout, valid, empty);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO.
- Successor to the fixed 4-bit/32-deep buffer used in the DTC tester BRAM stage.
- Adds configurable width and depth, programmable almost-full/almost-empty thresholds, overflow/underflow flags, a read-valid strobe and an optional first-word-fall-through read mode.
- Sits between the DTC stub producers and the downstream readout logic, on one clock domain.

Parameters:
- DATA_W, 4, data word width in bits.
- ADDR_W, 5, log2 of depth; depth = 2**ADDR_W (default 32).
- PROG_FULL_TH, 28, prog_full asserts when count >= this value; legal range 1..depth.
- PROG_EMPTY_TH, 4, prog_empty asserts when count <= this value; legal range 0..depth-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears pointers, count and flags.
- din  in  DATA_W  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- dout  out  DATA_W  read data.
- valid  out  1  dout holds a freshly read word.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- prog_full  out  1  count >= PROG_FULL_TH.
- prog_empty  out  1  count <= PROG_EMPTY_TH.
- wr_ack  out  1  previous-cycle write accepted.
- overflow  out  1  previous-cycle write rejected.
- underflow  out  1  previous-cycle read rejected.
- data_count  out  ADDR_W+1  words stored, 0..depth.

Behaviour:
- Reset (async assert, sync release on clk):
  - Pointers and count = 0; dout = 0.
  - valid, full, wr_ack, overflow, underflow, prog_full = 0.
  - empty = 1; prog_empty = 1 if PROG_EMPTY_TH >= 0 (always).
  - Reset mid-operation discards all contents; the first write after release lands at address 0.
- Storage: 2**ADDR_W x DATA_W array. Write and read pointers are ADDR_W bits and wrap modulo depth with no special case.
- Acceptance uses flags registered at the start of the cycle:
  - Write accepted iff wr_en && !full.
  - Read accepted iff rd_en && !empty.
- Simultaneous events:
  - wr_en && rd_en while full: read accepted, write rejected (overflow=1 next cycle); count becomes depth-1.
  - wr_en && rd_en while empty: write accepted, read rejected (underflow=1 next cycle); count becomes 1.
  - Both accepted otherwise: count unchanged, both pointers advance.
- Count: +1 on accepted write only, -1 on accepted read only. All flags are registered from the next count value, so they are valid in the same cycle data_count updates; no lag.
- wr_ack, overflow and underflow are 1-cycle pulses in the cycle after the request. overflow and underflow are non-sticky.
- Standard read mode (macro undefined):
  - dout is registered with the addressed word one cycle after an accepted read; valid=1 for that one cycle.
  - dout holds its value otherwise.
  - Read latency 1.
- No combinational path from din to dout.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout continuously shows the head word; valid = !empty.
  - rd_en while valid pops the head, and the next word (if any) appears the following cycle.
  - Read latency 0; first write visible on dout the cycle after it is accepted.
  - dout is don't-care while valid=0.
- Undefined: standard registered-read mode as described in Behaviour.
- Flags, counts, overflow and underflow are identical in both modes.

Test Plan (defaults DATA_W=4, ADDR_W=5):
- Reset then idle 3 cycles -> empty=1, prog_empty=1, full=0, data_count=0, valid=0; no ack/flag pulses.
- Write 0x0..0xF then 0x0..0xF (32 writes) -> wr_ack each cycle; prog_full=1 from count 28; full=1 at count 32; 33rd write -> overflow pulse 1 cycle, data_count stays 32.
- From full, read 32 words -> dout sequence 0x0..0xF,0x0..0xF with valid one cycle after each rd_en (standard mode); empty=1 at end; extra read -> underflow pulse, valid=0.
- From count 16, wr_en=rd_en=1 for 40 cycles with incrementing din -> data_count stays 16, output order preserved across pointer wrap, no overflow/underflow.
- Full, then wr_en=rd_en=1 one cycle -> read accepted, overflow=1, data_count=31; empty, wr_en=rd_en=1 -> underflow=1, data_count=1.
- Write 3 words, assert rst mid-burst asynchronously -> flags return to reset values immediately; with SYNC_FIFO_FWFT_EN, a subsequent write of 0xA shows dout=0xA, valid=1 the next cycle with no rd_en.
